md_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the E stage of the P7 MIPS pipeline. Owns the HI/LO architectural registers.
- Executes mult, multu, div and divu. Also services mthi and mtlo, and supplies HI/LO to mfhi and mflo.
- Drives `busy` to the hazard unit, which stalls any mul/div-class instruction in D while `busy` or `start` is high.
- Obeys `int_req`, so an instruction flushed by an interrupt or exception never alters HI/LO.

---
 rtl/md_unit_pkg.sv | 34 +++
 rtl/md_calc.sv | 59 +++++
 rtl/md_unit.sv | 111 +++++++++++
 tb/tb_md_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared encodings and default latencies for the HI/LO multiply/divide unit.
// MD_MADD_EN enables the accumulate opcodes 4..7; otherwise they are reserved no-ops.
package md_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MADD  = 3'd4,
        MD_MADDU = 3'd5,
        MD_MSUB  = 3'd6,
        MD_MSUBU = 3'd7
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

`ifdef MD_MADD_EN
    localparam logic MD_EXT_OPS = 1'b1;
`else
    localparam logic MD_EXT_OPS = 1'b0;
`endif

    function automatic logic md_op_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational result generator: 64-bit product/quotient-remainder (and, with
// MD_MADD_EN, accumulate) for one md_op, plus a divide-by-zero flag.
module md_calc
    import md_unit_pkg::*;
(
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s, prod_u;
    logic [31:0] b_nz;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;

    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign b_nz  = (b == 32'd0) ? 32'd1 : b;
    assign quo_u = a / b_nz;
    assign rem_u = a % b_nz;

    // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    assign a_mag = a[31] ? (32'd0 - a) : a;
    assign b_mag = b_nz[31] ? (32'd0 - b_nz) : b_nz;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign quo_s = (a[31] ^ b_nz[31]) ? (32'd0 - q_mag) : q_mag;
    assign rem_s = a[31] ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        result      = {hi, lo};
        div_by_zero = 1'b0;
        case (md_op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                result      = {rem_s, quo_s};
                div_by_zero = (b == 32'd0);
            end
            MD_DIVU: begin
                result      = {rem_u, quo_u};
                div_by_zero = (b == 32'd0);
            end
`ifdef MD_MADD_EN
            MD_MADD:  result = {hi, lo} + prod_s;
            MD_MADDU: result = {hi, lo} + prod_u;
            MD_MSUB:  result = {hi, lo} - prod_s;
            MD_MSUBU: result = {hi, lo} - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO; result commits after a fixed busy latency.
// MD_MADD_EN enables madd/maddu/msub/msubu on md_op 4..7.
//
// state   | meaning
// --------+-------------------------------------------------------------
// MD_IDLE | accepts start / mthi / mtlo; busy low
// MD_RUN  | counting down; result held in pend_*, HI/LO frozen; busy high
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic        int_req,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    md_state_e   state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;
    logic [31:0] hi_nxt, lo_nxt;
    logic        pend_wr, pend_wr_nxt;
    logic [63:0] calc_res;
    logic        calc_dbz;
    logic        op_legal;
    logic [3:0]  op_cycles;

    assign op_legal  = !md_op[2] || MD_EXT_OPS;
    assign op_cycles = md_op_is_div(md_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    assign busy      = (state == MD_RUN);

    md_calc u_calc (
        .md_op       (md_op),
        .a           (a),
        .b           (b),
        .hi          (hi),
        .lo          (lo),
        .result      (calc_res),
        .div_by_zero (calc_dbz)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MD_IDLE;
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend_hi <= pend_hi_nxt;
            pend_lo <= pend_lo_nxt;
            pend_wr <= pend_wr_nxt;
            hi      <= hi_nxt;
            lo      <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_hi_nxt = pend_hi;
        pend_lo_nxt = pend_lo;
        pend_wr_nxt = pend_wr;
        hi_nxt      = hi;
        lo_nxt      = lo;
        case (state)
            MD_IDLE: begin
                if (!int_req) begin
                    // A start always swallows same-cycle mthi/mtlo, even a reserved op.
                    if (start) begin
                        if (op_legal) begin
                            state_nxt   = MD_RUN;
                            cnt_nxt     = op_cycles;
                            pend_hi_nxt = calc_res[63:32];
                            pend_lo_nxt = calc_res[31:0];
                            pend_wr_nxt = !calc_dbz;
                        end
                    end else begin
                        if (hi_we) hi_nxt = a;
                        if (lo_we) lo_nxt = a;
                    end
                end
            end
            MD_RUN: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = MD_IDLE;
                    if (pend_wr) begin
                        hi_nxt = pend_hi;
                        lo_nxt = pend_lo;
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table driven through a scoreboard queue,
// plus hand sequences for int_req, mthi/mtlo, start/write collision and mid-op reset.
module tb_md_unit;

    localparam int N_MUL = 5;
    localparam int N_DIV = 10;

    logic        clk, reset, start, hi_we, lo_we, int_req, busy;
    logic [2:0]  md_op;
    logic [31:0] a, b, hi, lo;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cycles;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];

    md_unit dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .md_op   (md_op),
        .a       (a),
        .b       (b),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .int_req (int_req),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] hv, input logic [31:0] lv);
        @(negedge clk);
        hi_we = 1'b1; a = hv;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b1; a = lv;
        @(negedge clk);
        lo_we = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] av,
                          input logic [31:0] bv, input exp_t e);
        logic [31:0] old_hi, old_lo;
        int          cycles;
        bit          hold_ok;
        exp_t        got;
        old_hi = hi;
        old_lo = lo;
        start = 1'b1; md_op = op; a = av; b = bv;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        cycles  = 0;
        hold_ok = 1'b1;
        while (busy && cycles < 40) begin
            if (hi !== old_hi || lo !== old_lo) hold_ok = 1'b0;
            cycles++;
            @(negedge clk);
        end
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL %s: scoreboard empty at completion", name);
        end else begin
            got = sb.pop_front();
            check({name, " busy_cycles"}, 32'(cycles), 32'(got.cycles));
            check({name, " hold"}, {31'd0, hold_ok}, 32'd1);
            check({name, " hi"}, hi, got.hi);
            check({name, " lo"}, lo, got.lo);
        end
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; start = 1'b0; md_op = 3'd0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; int_req = 1'b0;

        vecs[0]  = '{3'd0, 32'hFFFF_FFFE, 32'd3,        32'h1234, 32'h5678, 32'hFFFF_FFFF, 32'hFFFF_FFFA, N_MUL};
        vecs[1]  = '{3'd3, 32'd100,       32'd7,        32'h0,    32'h0,    32'd2,         32'd14,        N_DIV};
        vecs[2]  = '{3'd2, 32'hFFFF_FFF9, 32'd2,        32'h0,    32'h0,    32'hFFFF_FFFF, 32'hFFFF_FFFD, N_DIV};
        vecs[3]  = '{3'd2, 32'd5,         32'd0,        32'h11,   32'h22,   32'h11,        32'h22,        N_DIV};
        vecs[4]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,32'h0,    32'h0,    32'hFFFF_FFFE, 32'h0000_0001, N_MUL};
        vecs[5]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,32'h5,    32'h6,    32'h0,         32'h8000_0000, N_DIV};
        vecs[6]  = '{3'd2, 32'd7,         32'hFFFF_FFFE,32'h0,    32'h0,    32'd1,         32'hFFFF_FFFD, N_DIV};
        vecs[7]  = '{3'd3, 32'd5,         32'd0,        32'hAA,   32'hBB,   32'hAA,        32'hBB,        N_DIV};
        vecs[8]  = '{3'd0, 32'h7FFF_FFFF, 32'h8000_0000,32'h0,    32'h0,    32'hC000_0000, 32'h8000_0000, N_MUL};
        vecs[9]  = '{3'd3, 32'hFFFF_FFFF, 32'h10,       32'h0,    32'h0,    32'hF,         32'h0FFF_FFFF, N_DIV};
        vecs[10] = '{3'd2, 32'hFFFF_FFF8, 32'hFFFF_FFFD,32'h0,    32'h0,    32'hFFFF_FFFE, 32'd2,         N_DIV};
        vecs[11] = '{3'd0, 32'd0,         32'hDEAD_BEEF,32'h9,    32'h9,    32'h0,         32'h0,         N_MUL};

        repeat (2) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            preload(vecs[i].pre_hi, vecs[i].pre_lo);
            e.hi = vecs[i].exp_hi; e.lo = vecs[i].exp_lo; e.cycles = vecs[i].cycles;
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, e);
        end

        // start under int_req is dropped, then mthi lands
        preload(32'h55, 32'h66);
        start = 1'b1; int_req = 1'b1; md_op = 3'd0; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; int_req = 1'b0;
        check("intreq busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("intreq busy later", {31'd0, busy}, 32'd0);
        check("intreq hi", hi, 32'h55);
        check("intreq lo", lo, 32'h66);
        hi_we = 1'b1; a = 32'hABCD;
        @(negedge clk);
        hi_we = 1'b0;
        check("mthi hi", hi, 32'hABCD);
        check("mthi lo", lo, 32'h66);

        // mtlo under int_req ignored; both writes together
        lo_we = 1'b1; int_req = 1'b1; a = 32'h999;
        @(negedge clk);
        lo_we = 1'b0; int_req = 1'b0;
        check("mtlo intreq lo", lo, 32'h66);
        hi_we = 1'b1; lo_we = 1'b1; a = 32'h4242;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        check("mthilo hi", hi, 32'h4242);
        check("mthilo lo", lo, 32'h4242);

        // start wins over same-cycle mthi
        start = 1'b1; hi_we = 1'b1; md_op = 3'd1; a = 32'd6; b = 32'd7;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        check("collide hi held", hi, 32'h4242);
        check("collide busy", {31'd0, busy}, 32'd1);
        repeat (N_MUL) @(negedge clk);
        check("collide done hi", hi, 32'd0);
        check("collide done lo", lo, 32'd42);

        // int_req in RUN does not cancel
        e.hi = 32'd0; e.lo = 32'd63; e.cycles = N_MUL;
        fork
            run_op("intreq_run", 3'd1, 32'd7, 32'd9, e);
            begin
                repeat (2) @(negedge clk);
                int_req = 1'b1;
                @(negedge clk);
                int_req = 1'b0;
            end
        join

`ifndef MD_MADD_EN
        start = 1'b1; md_op = 3'd5; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        check("reserved busy", {31'd0, busy}, 32'd0);
        check("reserved lo", lo, 32'd63);
`endif

        // reset mid-operation
        preload(32'h77, 32'h88);
        start = 1'b1; md_op = 3'd0; a = 32'd2; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre-reset busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset hi", hi, 32'd0);
        check("midreset lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (N_MUL + 3) @(negedge clk);
        check("postreset busy", {31'd0, busy}, 32'd0);
        check("postreset hi", hi, 32'd0);
        check("postreset lo", lo, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
